// File: rtl/ixu_mc_queue_if.sv
// Dispatch / wakeup / issue bundle of the IXU multi-cycle issue queue.
// The queue connects through the slave modport. Dispatch, the wakeup
// network and the multi-cycle pipe connect through the master modport.
interface ixu_mc_queue_if #(
    parameter int NWK = 3
);
    logic                 enq_valid_i;
    logic [17:0]          enq_data_i;     // {rs2, rs1, rob}
    logic                 enq_rs1_rdy_i;
    logic                 enq_rs2_rdy_i;
    logic                 enq_ready_o;
    logic [NWK-1:0]       wk_valid_i;
    logic [6*NWK-1:0]     wk_dest_i;      // port k at [6k+5:6k]
    logic [17:0]          data_o;         // {rs2, rs1, rob}
    logic                 valid_o;
    logic                 busy_i;

    modport slave (
        input  enq_valid_i, enq_data_i, enq_rs1_rdy_i, enq_rs2_rdy_i,
        input  wk_valid_i, wk_dest_i, busy_i,
        output enq_ready_o, data_o, valid_o
    );

    modport master (
        output enq_valid_i, enq_data_i, enq_rs1_rdy_i, enq_rs2_rdy_i,
        output wk_valid_i, wk_dest_i, busy_i,
        input  enq_ready_o, data_o, valid_o
    );
endinterface

// File: rtl/ixu_mc_queue.sv
// Collapsing issue queue for the IXU multi-cycle pipe.
// Slot 0 holds the oldest entry. The lowest-index ready slot issues, and
// the slots above it shift down by one. Issue is held off for a cycle after
// any cycle in which the pipe reported busy.
// Optional feature: define IXU_MC_QUEUE_STALL_CNT_EN to build a 32-bit
// counter of cycles in which a ready entry was held back by the stall.
module ixu_mc_queue #(
    parameter int DEPTH = 8,
    parameter int NWK   = 3
) (
    input  logic              core_clock_i,
    input  logic              core_reset_ni,
    input  logic              core_flush_i,
    ixu_mc_queue_if.slave     q_if,
    output logic [31:0]       stall_cnt_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef struct packed {
        logic       valid;
        logic [5:0] rob;
        logic [5:0] rs1;
        logic [5:0] rs2;
        logic       r1rdy;
        logic       r2rdy;
    } slot_t;

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    slot_t            woke   [DEPTH];
    slot_t            enq_slot;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] enq_pos;
    logic             stall_q, stall_d;
    logic [DEPTH-1:0] rdy;
    logic             any_rdy;
    logic [IDX_W-1:0] sel_idx;
    logic             issue;
    logic             enq;

    // Matches a source against every valid wakeup port. Register 0 is
    // never woken: it is already marked ready when the entry is enqueued.
    function automatic logic wk_hit(input logic [5:0]       src,
                                    input logic [NWK-1:0]   v,
                                    input logic [6*NWK-1:0] d);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NWK; k++) begin
            if (v[k] && (d[6*k +: 6] == src) && (src != 6'd0)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Resident entries with the current cycle's wakeups folded in
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = slot_q[i];
            woke[i].r1rdy = slot_q[i].r1rdy | wk_hit(slot_q[i].rs1, q_if.wk_valid_i, q_if.wk_dest_i);
            woke[i].r2rdy = slot_q[i].r2rdy | wk_hit(slot_q[i].rs2, q_if.wk_valid_i, q_if.wk_dest_i);
        end
    end

    // Oldest-first select: scan downward so the lowest ready index wins
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that leaves one unassigned infers a latch.
        any_rdy = 1'b0;
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = slot_q[i].valid & slot_q[i].r1rdy & slot_q[i].r2rdy;
            if (rdy[i]) begin
                any_rdy = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // The issue strobe does not look at busy_i: the pipe's busy depends on valid_o.
    assign q_if.data_o      = any_rdy ? {slot_q[sel_idx].rs2, slot_q[sel_idx].rs1, slot_q[sel_idx].rob} : 18'd0;
    assign q_if.valid_o     = any_rdy & ~stall_q & ~core_flush_i;
    assign q_if.enq_ready_o = (count_q != CNT_W'(DEPTH));

    assign issue   = q_if.valid_o;
    assign enq     = q_if.enq_valid_i & q_if.enq_ready_o & ~core_flush_i;
    assign enq_pos = issue ? (count_q - CNT_W'(1)) : count_q;

    // Incoming entry; a same-cycle wakeup is bypassed into its ready bits
    always_comb begin
        enq_slot.valid = 1'b1;
        enq_slot.rob   = q_if.enq_data_i[5:0];
        enq_slot.rs1   = q_if.enq_data_i[11:6];
        enq_slot.rs2   = q_if.enq_data_i[17:12];
        enq_slot.r1rdy = q_if.enq_rs1_rdy_i | (enq_slot.rs1 == 6'd0)
                       | wk_hit(enq_slot.rs1, q_if.wk_valid_i, q_if.wk_dest_i);
        enq_slot.r2rdy = q_if.enq_rs2_rdy_i | (enq_slot.rs2 == 6'd0)
                       | wk_hit(enq_slot.rs2, q_if.wk_valid_i, q_if.wk_dest_i);
    end

    // Next slot contents: collapse over the issued slot, then write the new entry
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            slot_d[i] = (issue && (i >= int'(sel_idx))) ? woke[i + 1] : woke[i];
        end
        slot_d[DEPTH-1] = (issue && (int'(sel_idx) <= DEPTH - 1)) ? slot_t'('0) : woke[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (enq && (CNT_W'(i) == enq_pos)) slot_d[i] = enq_slot;
            if (core_flush_i)                  slot_d[i] = '0;
        end
    end

    // Occupancy and stall next-state; flush empties the queue and clears the stall
    always_comb begin
        count_d = count_q;
        if (enq && !issue)      count_d = count_q + CNT_W'(1);
        else if (!enq && issue) count_d = count_q - CNT_W'(1);
        if (core_flush_i)       count_d = '0;
        stall_d = core_flush_i ? 1'b0 : q_if.busy_i;
    end

    // Queue state registers
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            // NOTE: the slots are flops, not a RAM, so they are all reset; the valid bits must start cleared.
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
        end else begin
            // NOTE: sequential state always uses <=, so every register samples the pre-edge values.
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

`ifdef IXU_MC_QUEUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'd1;

    // Count cycles in which a ready entry is held back by the stall; only reset clears the count
    always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
        if (!core_reset_ni) begin
            stall_cnt_q <= '0;
        end else if (any_rdy && stall_q && !core_flush_i) begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ixu_mc_queue.sv
// Directed bench for ixu_mc_queue (DEPTH=8, NWK=3): a table of single-cycle
// vectors plus hand-written sequences for full, division stall and reset.
module tb_ixu_mc_queue;
    localparam int NWK = 3;
`ifdef IXU_MC_QUEUE_STALL_CNT_EN
    localparam logic [31:0] STALL_EXP = 32'd34;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] stall_cnt;
    int          n_tests;
    int          n_fail;

    ixu_mc_queue_if #(.NWK(NWK)) q_if ();

    ixu_mc_queue #(.DEPTH(8), .NWK(NWK)) dut (
        .core_clock_i  (clk),
        .core_reset_ni (rst_n),
        .core_flush_i  (flush),
        .q_if          (q_if),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        ev;
        logic [17:0] ed;
        logic        r1;
        logic        r2;
        logic [2:0]  wv;
        logic [17:0] wd;
        logic        bz;
        logic        xv;
        logic [17:0] xd;
        logic        xr;
    } vec_t;

    vec_t vecs [37];

    function automatic logic [17:0] pk(input int rs2, input int rs1, input int rob);
        return {rs2[5:0], rs1[5:0], rob[5:0]};
    endfunction

    function automatic logic [17:0] wkd(input int port, input int dest);
        logic [17:0] r;
        r = '0;
        r[6*port +: 6] = dest[5:0];
        return r;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic ev, input logic [17:0] ed,
                                 input logic r1, input logic r2, input logic [2:0] wv,
                                 input logic [17:0] wd, input logic bz, input logic xv,
                                 input logic [17:0] xd, input logic xr);
        vec_t v;
        v.fl = fl; v.ev = ev; v.ed = ed; v.r1 = r1; v.r2 = r2;
        v.wv = wv; v.wd = wd; v.bz = bz; v.xv = xv; v.xd = xd; v.xr = xr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic ev, input logic [17:0] ed,
                         input logic r1, input logic r2, input logic [2:0] wv,
                         input logic [17:0] wd, input logic bz);
        flush              = fl;
        q_if.enq_valid_i   = ev;
        q_if.enq_data_i    = ed;
        q_if.enq_rs1_rdy_i = r1;
        q_if.enq_rs2_rdy_i = r2;
        q_if.wk_valid_i    = wv;
        q_if.wk_dest_i     = wd;
        q_if.busy_i        = bz;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 3'b000, 18'd0, 1'b0);
    endtask

    // Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();

        // Reset-state values while reset is held and after its release.
        #2;
        check("rst valid_o", 32'(q_if.valid_o), 32'd0);
        check("rst data_o", 32'(q_if.data_o), 32'd0);
        check("rst enq_ready_o", 32'(q_if.enq_ready_o), 32'd1);
        check("rst stall_cnt_o", stall_cnt, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Division stall: the division issues with busy high, busy stays high for 34 cycles,
        // and the next ready entry issues only in the cycle after busy drops.
        drive(1'b0, 1'b1, pk(0, 0, 20), 1'b1, 1'b1, 3'b000, 18'd0, 1'b0);
        @(negedge clk);
        check("div pre valid_o", 32'(q_if.valid_o), 32'd0);
        next_cycle();
        drive(1'b0, 1'b1, pk(0, 0, 21), 1'b1, 1'b1, 3'b000, 18'd0, 1'b1);
        @(negedge clk);
        check("div issue valid_o", 32'(q_if.valid_o), 32'd1);
        check("div issue data_o", 32'(q_if.data_o), 32'(pk(0, 0, 20)));
        next_cycle();
        for (int j = 1; j <= 33; j++) begin
            drive(1'b0, (j == 1), pk(0, 0, 22), 1'b1, 1'b1, 3'b000, 18'd0, 1'b1);
            @(negedge clk);
            check($sformatf("div busy%0d valid_o", j), 32'(q_if.valid_o), 32'd0);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("div busy-drop valid_o", 32'(q_if.valid_o), 32'd0);
        check("div busy-drop data_o", 32'(q_if.data_o), 32'(pk(0, 0, 21)));
        next_cycle();
        @(negedge clk);
        check("div done valid_o", 32'(q_if.valid_o), 32'd1);
        check("div done data_o", 32'(q_if.data_o), 32'(pk(0, 0, 21)));
        check("div stall_cnt_o", stall_cnt, STALL_EXP);
        next_cycle();
        @(negedge clk);
        check("div next valid_o", 32'(q_if.valid_o), 32'd1);
        check("div next data_o", 32'(q_if.data_o), 32'(pk(0, 0, 22)));
        next_cycle();
        @(negedge clk);
        check("div empty valid_o", 32'(q_if.valid_o), 32'd0);
        next_cycle();

        // Single-cycle vectors: fl ev ed r1 r2 wv wd bz | valid data ready
        vecs[0]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[1]  = mkv(0, 1, pk(0, 0, 5),   0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[2]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(0, 0, 5),   1);
        vecs[3]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[4]  = mkv(0, 1, pk(0, 12, 1),  0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[5]  = mkv(0, 1, pk(4, 3, 2),   1, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[6]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(4, 3, 2),   1);
        vecs[7]  = mkv(0, 0, 18'd0,         0, 0, 3'b010, wkd(1, 12),  0, 0, 18'd0,         1);
        vecs[8]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(0, 12, 1),  1);
        vecs[9]  = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[10] = mkv(0, 1, pk(8, 7, 3),   1, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[11] = mkv(0, 0, 18'd0,         0, 0, 3'b001, wkd(1, 8),   0, 0, 18'd0,         1);
        vecs[12] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[13] = mkv(0, 0, 18'd0,         0, 0, 3'b100, wkd(2, 8),   0, 0, 18'd0,         1);
        vecs[14] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(8, 7, 3),   1);
        vecs[15] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[16] = mkv(0, 1, pk(20, 0, 6),  0, 0, 3'b001, wkd(0, 20),  0, 0, 18'd0,         1);
        vecs[17] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(20, 0, 6),  1);
        vecs[18] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[19] = mkv(0, 1, pk(1, 1, 9),   1, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[20] = mkv(0, 1, pk(2, 2, 10),  1, 1, 3'b000, 18'd0,       0, 1, pk(1, 1, 9),   1);
        vecs[21] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(2, 2, 10),  1);
        vecs[22] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[23] = mkv(0, 1, pk(0, 0, 11),  0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[24] = mkv(0, 1, pk(0, 0, 12),  0, 0, 3'b000, 18'd0,       1, 1, pk(0, 0, 11),  1);
        vecs[25] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, pk(0, 0, 12),  1);
        vecs[26] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 1, pk(0, 0, 12),  1);
        vecs[27] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[28] = mkv(0, 1, pk(0, 30, 13), 0, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[29] = mkv(0, 1, pk(0, 30, 14), 0, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[30] = mkv(0, 1, pk(0, 30, 15), 0, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[31] = mkv(1, 1, pk(0, 0, 16),  1, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[32] = mkv(0, 0, 18'd0,         0, 0, 3'b001, wkd(0, 30),  0, 0, 18'd0,         1);
        vecs[33] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[34] = mkv(0, 1, pk(0, 0, 17),  1, 1, 3'b000, 18'd0,       0, 0, 18'd0,         1);
        vecs[35] = mkv(1, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, pk(0, 0, 17),  1);
        vecs[36] = mkv(0, 0, 18'd0,         0, 0, 3'b000, 18'd0,       0, 0, 18'd0,         1);

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].ev, vecs[i].ed, vecs[i].r1, vecs[i].r2,
                  vecs[i].wv, vecs[i].wd, vecs[i].bz);
            @(negedge clk);
            check($sformatf("v%0d valid_o", i), 32'(q_if.valid_o), 32'(vecs[i].xv));
            check($sformatf("v%0d data_o", i), 32'(q_if.data_o), 32'(vecs[i].xd));
            check($sformatf("v%0d enq_ready_o", i), 32'(q_if.enq_ready_o), 32'(vecs[i].xr));
            next_cycle();
        end

        // Fill: eight entries waiting on register 9, then one wakeup drains them in order.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, pk(0, 9, i), 1'b0, 1'b0, 3'b000, 18'd0, 1'b0);
            @(negedge clk);
            check($sformatf("fill%0d enq_ready_o", i), 32'(q_if.enq_ready_o), 32'd1);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("full enq_ready_o", 32'(q_if.enq_ready_o), 32'd0);
        check("full valid_o", 32'(q_if.valid_o), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 18'd0, 1'b0, 1'b0, 3'b001, wkd(0, 9), 1'b0);
        @(negedge clk);
        check("full wake valid_o", 32'(q_if.valid_o), 32'd0);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            // The first drain cycle offers an entry that a full queue must not take.
            drive(1'b0, (i == 0), pk(0, 0, 63), 1'b1, 1'b1, 3'b000, 18'd0, 1'b0);
            @(negedge clk);
            check($sformatf("drain%0d valid_o", i), 32'(q_if.valid_o), 32'd1);
            check($sformatf("drain%0d data_o", i), 32'(q_if.data_o), 32'(pk(0, 9, i)));
            check($sformatf("drain%0d enq_ready_o", i), 32'(q_if.enq_ready_o), (i == 0) ? 32'd0 : 32'd1);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("drain end valid_o", 32'(q_if.valid_o), 32'd0);
        check("drain end data_o", 32'(q_if.data_o), 32'd0);
        next_cycle();

        // Asynchronous reset in the middle of a cycle with a ready entry.
        drive(1'b0, 1'b1, pk(0, 0, 40), 1'b1, 1'b1, 3'b000, 18'd0, 1'b0);
        @(negedge clk);
        check("arst pre valid_o", 32'(q_if.valid_o), 32'd0);
        next_cycle();
        idle();
        #1;
        check("arst live valid_o", 32'(q_if.valid_o), 32'd1);
        check("arst live data_o", 32'(q_if.data_o), 32'(pk(0, 0, 40)));
        rst_n = 1'b0;
        #1;
        check("arst valid_o", 32'(q_if.valid_o), 32'd0);
        check("arst data_o", 32'(q_if.data_o), 32'd0);
        check("arst enq_ready_o", 32'(q_if.enq_ready_o), 32'd1);
        check("arst stall_cnt_o", stall_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check("post-rst valid_o", 32'(q_if.valid_o), 32'd0);
        check("post-rst data_o", 32'(q_if.data_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ixu_mc_queue.md
# ixu_mc_queue

Issue queue feeding the IXU multi-cycle pipe (ALU/JAL/JALR/LUI/AUIPC/MUL/DIV). It holds dispatched micro-ops, tracks source-operand readiness from wakeup broadcasts, and issues the oldest ready entry as an 18-bit packet. Issue is throttled by the pipe's `busy` so that a division stalls further issue until it completes. It sits between dispatch and the multi-cycle pipe: it drives that pipe's `data_i`/`valid_i` and consumes its `busy_o`.

## Interface
- `DEPTH`, default 8 – queue entries; power of two, range 2..16.
- `NWK`, default 3 – number of wakeup broadcast ports.

Ports:
- `core_clock_i` – in, 1 – core clock.
- `core_reset_ni` – in, 1 – asynchronous active-low reset.
- `core_flush_i` – in, 1 – synchronous pipeline flush.
- `enq_valid_i` – in, 1 – dispatch presents a micro-op.
- `enq_data_i` – in, 18 – packed micro-op: {rs2[5:0], rs1[5:0], rob[5:0]}.
- `enq_rs1_rdy_i` – in, 1 – rs1 already available at dispatch.
- `enq_rs2_rdy_i` – in, 1 – rs2 already available at dispatch.
- `enq_ready_o` – out, 1 – queue can accept a micro-op this cycle.
- `wk_valid_i` – in, NWK – wakeup strobes.
- `wk_dest_i` – in, 6*NWK – wakeup physical registers; port k uses bits [6k+5:6k].
- `data_o` – out, 18 – issued packet, same packing as `enq_data_i`.
- `valid_o` – out, 1 – issue strobe.
- `busy_i` – in, 1 – pipe busy; combinationally dependent on `valid_o`.
- `stall_cnt_o` – out, 32 – stall-cycle counter (see Configuration).

## Operation
- Collapsing queue: slot 0 is the oldest entry. Each slot holds valid, rob[5:0], rs1, rs2, r1rdy, r2rdy. `count` is 0..DEPTH.
- An entry is ready when r1rdy & r2rdy.
- Physical register 0 is always ready: a source equal to 0 sets its ready bit at enqueue.
- Wakeup: any valid port k with `wk_dest_i` == src sets the matching ready bit at the next clock edge. Wakeup carrying dest 0 is ignored.
- Enqueue bypass: a same-cycle wakeup match is ORed into the ready bits of the entry being enqueued.
- Select: lowest-index ready slot. `data_o` = that slot's fields; `data_o` = 0 when no slot is ready.
- `valid_o` = any ready slot & !stall_q & !core_flush_i. `valid_o` never depends combinationally on `busy_i`, which prevents a combinational loop.
- `stall_q` register: stall_q <= busy_i every cycle. Reset and flush both clear it.
- Every cycle with `valid_o`=1 consumes the selected slot. Slots above it shift down by one, and `count` decrements.
- `enq_ready_o` = (count != DEPTH). Enqueue occurs when enq_valid_i & enq_ready_o.
  - The entry is written to slot `count`.
  - If an issue happens in the same cycle, the entry is written to slot `count`-1 instead.
  - `count` is unchanged when enqueue and issue coincide.
- Flush: all slots become invalid and `count`=0. Flush beats a simultaneous enqueue, which is dropped.

## Timing
- Reset (async assert, sync release): count=0, all slots invalid, stall_q=0, stall counter=0. Outputs: valid_o=0, data_o=0, enq_ready_o=1, stall_cnt_o=0.
- Enqueue with both sources ready at cycle t → `valid_o` at t+1 at the earliest.
- Wakeup at cycle t for a resident entry → the entry is eligible at t+1.
- Division issued at cycle t: `busy_i`=1 at t, so stall_q=1 from t+1. Issue is blocked until the cycle after `busy_i` drops (the div_done cycle). This is exactly one bubble after completion.
- Non-division issue: `busy_i`=0, so back-to-back issue at one per cycle.
- Full with a simultaneous issue: `enq_ready_o` stays 0 for that cycle; there is no full-bypass.

## Configuration
- `IXU_MC_QUEUE_STALL_CNT_EN` defined:
  - `stall_cnt_o` increments by one (wrapping at 2^32) on each cycle with ≥1 ready entry & stall_q & !core_flush_i.
  - It is cleared only by reset.
- Not defined: `stall_cnt_o` is tied to 0 and no counter logic is generated.

## Test plan
- Reset, then enqueue {rs2=0, rs1=0, rob=5} with rdy=0/0 → valid_o=1 next cycle with data_o=0x00005; count returns to 0.
- Enqueue rob=1 (rs1=12, not ready), then rob=2 (all ready) → rob=2 issues first. Wake 12 on port 1 → rob=1 issues the following cycle.
- Fill DEPTH=8 entries with rs1=9 not ready → enq_ready_o=0. Wake 9 → eight consecutive issues of rob 0..7 in order; enq_ready_o=1 after the first issue.
- Issue a division; hold busy_i=1 for 34 cycles with two more entries ready → no valid_o until the cycle after busy_i falls. With the macro defined, stall_cnt_o=34.
- Enqueue rs2=20 while a wakeup for 20 arrives in the same cycle → entry issues next cycle (bypass).
- Assert core_flush_i alongside enq_valid_i with 3 entries resident → next cycle valid_o=0, enq_ready_o=1, and the enqueued op is never issued. Deassert core_reset_ni mid-operation → outputs at reset values asynchronously.
